// File: rtl/op2_gather.sv
// Two-bank serial-to-parallel gather feeding the 16-input stage-2 adder.
// Optional OP2_GATHER_PAD_EN adds in_last for early, zero-padded bundles.
module op2_gather #(
    parameter int DATA_W = 12,
    parameter int NUM    = 16,
    localparam int CW    = $clog2(NUM + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
`ifdef OP2_GATHER_PAD_EN
    input  logic                  in_last,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [NUM*DATA_W-1:0] words_out,
    output logic [CW-1:0]         fill_cnt
);

    typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_t;

    bank_t                         st_q [2];
    bank_t                         st_d [2];
    logic                          sel_q, sel_d;
    logic [CW-1:0]                 cnt_q, cnt_d;
    logic [NUM-1:0][DATA_W-1:0]    mem [2];
    logic                          fill_b, out_b;
    logic                          accept, deliver, last_word;

    assign fill_b    = sel_q;
    assign out_b     = ~sel_q;
    assign in_ready  = (st_q[fill_b] != FULL);
    assign out_valid = (st_q[out_b] == FULL);
    // The out bank is never written while it is the out bank, so it doubles
    // as the output register and keeps its contents after delivery.
    assign words_out = mem[out_b];
    assign fill_cnt  = cnt_q;
    assign accept    = in_valid && in_ready;
    assign deliver   = out_valid && out_ready;
`ifdef OP2_GATHER_PAD_EN
    assign last_word = (cnt_q == CW'(NUM - 1)) || in_last;
`else
    assign last_word = (cnt_q == CW'(NUM - 1));
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            st_q[0] <= EMPTY;
            st_q[1] <= EMPTY;
            sel_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            st_q[0] <= st_d[0];
            st_q[1] <= st_d[1];
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        st_d[0] = st_q[0];
        st_d[1] = st_q[1];
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        if (deliver)
            st_d[out_b] = EMPTY;
        if (accept) begin
            if (last_word) begin
                st_d[fill_b] = FULL;
                cnt_d        = '0;
            end else begin
                st_d[fill_b] = FILLING;
                cnt_d        = cnt_q + 1'b1;
            end
        end
        // Swap as soon as a full bank has an empty (or just-drained) out bank.
        if (st_d[fill_b] == FULL && st_d[out_b] == EMPTY)
            sel_d = ~sel_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NUM; i++) begin
                if (CW'(i) == cnt_q)
                    mem[fill_b][i] <= in_data;
`ifdef OP2_GATHER_PAD_EN
                else if (in_last && CW'(i) > cnt_q)
                    mem[fill_b][i] <= '0;
`endif
            end
        end
    end

endmodule
